// File: rtl/fetch_sequencer.sv
// Fetch/PC sequencer for the 3-stage RISC-V core.
// This block drives IMEM addressing and the decode and execute instruction
// registers. It absorbs load-use holds and turns a resolved redirect into a
// one-cycle FLUSH window that squashes the wrong-path slots. It also keeps
// the cycle and retired-instruction perf counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Hold,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        counter_rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] Inst_Fetch,
    output logic [31:0] PC_Fetch,
    output logic [31:0] Inst_Decode,
    output logic [31:0] PC_Decode,
    output logic [31:0] Inst_Execute,
    output logic [31:0] PC_Execute,
    output logic        control_hazards_sum,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] target_q;
    logic        valid_D;
    logic        valid_E;
    logic        take_redirect;
    logic        squash;

    // In FLUSH, a redirect is ignored because the decode slot already holds a bubble.
    assign take_redirect = (state == RUN) && redirect_valid;
    assign squash        = take_redirect || (state == FLUSH) || Hold;

    // The FLUSH slot carries the word fetched from the wrong path, so it is replaced by a bubble.
    assign Inst_Fetch = (state == FLUSH) ? NOP : imem_dout;

    // Select the IMEM address. PC_Fetch follows this address one cycle later,
    // so it always names the word that is on imem_dout.
    always_comb begin
        // NOTE: assign a default first so that no path through the block infers a latch.
        imem_addr = PC_Fetch + 32'd4;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (state == FLUSH) begin
            imem_addr = target_q;
        end else if (redirect_valid || Hold) begin
            imem_addr = PC_Fetch;
        end
    end

    // Pipeline registers, the redirect FSM and the squash-window flag.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments so that every register samples pre-edge values.
        if (rst) begin
            state               <= RUN;
            target_q            <= 32'd0;
            control_hazards_sum <= 1'b0;
            PC_Fetch            <= RESET_PC;
            Inst_Decode         <= NOP;
            PC_Decode           <= 32'd0;
            valid_D             <= 1'b0;
            Inst_Execute        <= NOP;
            PC_Execute          <= 32'd0;
            valid_E             <= 1'b0;
        end else begin
            PC_Fetch <= imem_addr;

            if (squash) begin
                Inst_Decode <= NOP;
                valid_D     <= 1'b0;
            end else begin
                Inst_Decode <= Inst_Fetch;
                PC_Decode   <= PC_Fetch;
                valid_D     <= 1'b1;
            end

            Inst_Execute <= Inst_Decode;
            PC_Execute   <= PC_Decode;
            valid_E      <= valid_D;

            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        target_q            <= redirect_target;
                        state               <= FLUSH;
                        control_hazards_sum <= 1'b1;
                    end
                end
                FLUSH: begin
                    state               <= RUN;
                    control_hazards_sum <= 1'b0;
                end
                default: begin
                    state               <= RUN;
                    control_hazards_sum <= 1'b0;
                end
            endcase
        end
    end

    // Perf counters. A clear takes priority over the increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || counter_rst) begin
            cycle_count <= 32'd0;
            inst_count  <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (valid_E) begin
                inst_count <= inst_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer.
// The bench runs directed scenarios and then randomized cycles. A slot-level
// reference model predicts every output in every cycle.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        Hold;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        counter_rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] Inst_Fetch;
    logic [31:0] PC_Fetch;
    logic [31:0] Inst_Decode;
    logic [31:0] PC_Decode;
    logic [31:0] Inst_Execute;
    logic [31:0] PC_Execute;
    logic        control_hazards_sum;
    logic [31:0] cycle_count;
    logic [31:0] inst_count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_sequencer #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .Hold                (Hold),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .counter_rst         (counter_rst),
        .imem_addr           (imem_addr),
        .imem_dout           (imem_dout),
        .Inst_Fetch          (Inst_Fetch),
        .PC_Fetch            (PC_Fetch),
        .Inst_Decode         (Inst_Decode),
        .PC_Decode           (PC_Decode),
        .Inst_Execute        (Inst_Execute),
        .PC_Execute          (PC_Execute),
        .control_hazards_sum (control_hazards_sum),
        .cycle_count         (cycle_count),
        .inst_count          (inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The IMEM word is an addi with rd=x1 and an immediate built from the
    // address. It is never equal to NOP and differs between nearby words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[13:2] ^ 12'h5a5, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    // Synchronous IMEM with a 1-cycle read latency.
    always @(posedge clk) imem_dout <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. Each pipeline slot is an (instruction, pc, valid)
    // triple that moves forward one stage per cycle. The model also tracks
    // the fetch PC, the word IMEM returns and whether a squash window is open.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } slot_t;

    slot_t       m_dec;
    slot_t       m_exe;
    logic [31:0] m_pc;
    logic [31:0] m_dout;
    logic [31:0] m_target;
    bit          m_flush;
    logic [31:0] m_cyc;
    logic [31:0] m_ins;

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_dout   = mem_word(RESET_PC);
        m_target = 32'd0;
        m_flush  = 1'b0;
        m_dec    = '{inst: NOP, pc: 32'd0, valid: 1'b0};
        m_exe    = '{inst: NOP, pc: 32'd0, valid: 1'b0};
        m_cyc    = 32'd0;
        m_ins    = 32'd0;
    endtask

    // Run one clock cycle: drive the inputs, check every output against the
    // model, advance the model, then move to 1 time unit after the next edge.
    task automatic step(input logic h, input logic rv, input logic [31:0] rt,
                        input logic cr, input logic r);
        logic [31:0] e_addr;
        logic [31:0] e_fetch;
        Hold            = h;
        redirect_valid  = rv;
        redirect_target = rt;
        counter_rst     = cr;
        rst             = r;
        #1;
        if (r)            e_addr = RESET_PC;
        else if (m_flush) e_addr = m_target;
        else if (rv || h) e_addr = m_pc;
        else              e_addr = m_pc + 32'd4;
        e_fetch = m_flush ? NOP : m_dout;

        check("imem_addr", imem_addr, e_addr);
        check("Inst_Fetch", Inst_Fetch, e_fetch);
        check("PC_Fetch", PC_Fetch, m_pc);
        check("Inst_Decode", Inst_Decode, m_dec.inst);
        check("PC_Decode", PC_Decode, m_dec.pc);
        check("Inst_Execute", Inst_Execute, m_exe.inst);
        check("PC_Execute", PC_Execute, m_exe.pc);
        check("control_hazards_sum", {31'd0, control_hazards_sum}, {31'd0, m_flush});
        check("cycle_count", cycle_count, m_cyc);
        check("inst_count", inst_count, m_ins);

        if (r) begin
            model_reset();
        end else begin
            m_ins = cr ? 32'd0 : m_ins + (m_exe.valid ? 32'd1 : 32'd0);
            m_cyc = cr ? 32'd0 : m_cyc + 32'd1;
            m_exe = m_dec;
            if (m_flush || rv || h) m_dec = '{inst: NOP, pc: m_dec.pc, valid: 1'b0};
            else                    m_dec = '{inst: e_fetch, pc: m_pc, valid: 1'b1};
            if (!m_flush && rv) begin
                m_target = rt;
                m_flush  = 1'b1;
            end else begin
                m_flush = 1'b0;
            end
            m_pc   = e_addr;
            m_dout = mem_word(e_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst             = 1'b1;
        Hold            = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        counter_rst     = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset values.
        do_reset();
        check("rst PC_Fetch", PC_Fetch, 32'h4000_0000);
        check("rst Inst_Decode", Inst_Decode, 32'h0000_0013);
        check("rst Inst_Execute", Inst_Execute, 32'h0000_0013);
        check("rst chs", {31'd0, control_hazards_sum}, 32'd0);
        check("rst cycle_count", cycle_count, 32'd0);

        // Straight-line fetch.
        idle(3);
        check("straight inst_count", inst_count, 32'd1);
        check("straight cycle_count", cycle_count, 32'd3);
        idle(5);

        // Hold for one cycle while PC_Fetch is 0x4000_0008.
        do_reset();
        idle(2);
        check("hold PC_Fetch", PC_Fetch, 32'h4000_0008);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("hold Inst_Decode bubble", Inst_Decode, NOP);
        idle(1);
        check("hold Inst_Decode word", Inst_Decode, mem_word(32'h4000_0008));
        idle(4);

        // Redirect at cycle t.
        step(1'b0, 1'b1, 32'h4000_0100, 1'b0, 1'b0);
        check("redir t+1 chs", {31'd0, control_hazards_sum}, 32'd1);
        check("redir t+1 Inst_Decode", Inst_Decode, NOP);
        idle(1);
        check("redir t+2 Inst_Decode", Inst_Decode, NOP);
        check("redir t+2 PC_Fetch", PC_Fetch, 32'h4000_0100);
        check("redir t+2 chs", {31'd0, control_hazards_sum}, 32'd0);
        idle(1);
        check("redir t+3 PC_Decode", PC_Decode, 32'h4000_0100);
        idle(3);

        // Redirect together with Hold, then a redirect during FLUSH that must be ignored.
        step(1'b1, 1'b1, 32'h4000_0100, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h4000_0200, 1'b0, 1'b0);
        check("redir+hold t+2 PC_Fetch", PC_Fetch, 32'h4000_0100);
        idle(4);

        // Reset asserted during FLUSH.
        step(1'b0, 1'b1, 32'h4000_0300, 1'b0, 1'b0);
        check("flush chs before rst", {31'd0, control_hazards_sum}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check("rst-in-flush chs", {31'd0, control_hazards_sum}, 32'd0);
        check("rst-in-flush PC_Fetch", PC_Fetch, RESET_PC);
        idle(4);

        // Counter clear in the middle of a run.
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("counter_rst cycle 0", cycle_count, 32'd0);
        idle(1);
        check("counter_rst cycle 1", cycle_count, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic h, rv, cr, r;
            logic [31:0] rt;
            h  = ($urandom_range(0, 5) == 0);
            rv = ($urandom_range(0, 7) == 0);
            cr = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 127) == 0);
            rt = $urandom;
            step(h, rv, rt, cr, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch/PC sequencer for the 3-stage RISC-V core. It produces the instruction stream that the decode control unit consumes: `Inst_Fetch`, `Inst_Decode`, `Inst_Execute` and their PCs. It honours the decode-side `Hold` load-use stall and turns an execute-stage redirect into a registered PC change, driving `control_hazards_sum` during the squash window. It also keeps the cycle and retired-instruction counters used by the CSR/perf path.

## Interface

Parameters:
- `RESET_PC`, 32'h4000_0000, first fetch address after reset.
- `NOP`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `Hold` in 1: load-use stall request from the decode control unit.
- `redirect_valid` in 1: a taken branch, JAL or JALR was resolved in the stage holding `Inst_Decode`.
- `redirect_target` in 32: target address for the redirect.
- `counter_rst` in 1: clears both perf counters.
- `imem_addr` out 32: IMEM read address. IMEM is a synchronous BRAM with 1-cycle read latency.
- `imem_dout` in 32: IMEM read data.
- `Inst_Fetch` out 32: current fetched instruction (combinational).
- `PC_Fetch` out 32: address of `Inst_Fetch`.
- `Inst_Decode`, `PC_Decode` out 32 each: decode/execute stage registers.
- `Inst_Execute`, `PC_Execute` out 32 each: writeback stage registers.
- `control_hazards_sum` out 1: high while wrong-path instructions are being squashed.
- `cycle_count`, `inst_count` out 32 each: perf counters.

## Operation

- FSM states: RUN and FLUSH. Reset enters RUN.
- `target_q` (32b) and the valid bits `valid_D`/`valid_E` are internal.
- **`imem_addr`** (combinational):
  - `rst`: RESET_PC.
  - FLUSH: `target_q`.
  - RUN with `redirect_valid` or `Hold`: `PC_Fetch`.
  - Otherwise: `PC_Fetch`+4 (mod 2^32).
- **`PC_Fetch` next value:** follows `imem_addr`, so `PC_Fetch` always names the word currently on `imem_dout`.
- **`Inst_Fetch`:** NOP in FLUSH, else `imem_dout`.
- **Squash condition:** (RUN & `redirect_valid`) | FLUSH | `Hold`.
  - When set: `Inst_Decode` <= NOP, `valid_D` <= 0, `PC_Decode` holds.
  - Otherwise: `Inst_Decode` <= `Inst_Fetch`, `PC_Decode` <= `PC_Fetch`, `valid_D` <= 1.
- **Execute stage:** `Inst_Execute` <= `Inst_Decode`, `PC_Execute` <= `PC_Decode`, `valid_E` <= `valid_D`, every cycle.
- **FSM transitions:**
  - RUN with `redirect_valid`: `target_q` <= `redirect_target`, go to FLUSH.
  - FLUSH always returns to RUN after one cycle.
  - `redirect_valid` is ignored in FLUSH, because the decode slot then holds a bubble.
- **Priority:** redirect over `Hold`. In RUN, `Hold` together with `redirect_valid` behaves as redirect only. `Hold` is ignored in FLUSH.
- **`control_hazards_sum`:** 1 exactly in FLUSH, registered from the state.
- **Counters:**
  - `cycle_count` +1 every non-reset cycle.
  - `inst_count` +1 each cycle `valid_E`=1.
  - `counter_rst` (or `rst`) loads 0 instead. Both wrap at 2^32.

## Timing

- **Reset values:**
  - `PC_Fetch`=RESET_PC; `imem_addr`=RESET_PC while `rst` is high.
  - `Inst_Decode`=`Inst_Execute`=NOP; `PC_Decode`=`PC_Execute`=0.
  - `valid_D`=`valid_E`=0; state RUN; `control_hazards_sum`=0; counters 0.
  - `Inst_Fetch` = word at RESET_PC in the first cycle after release.
- **Latency:** an instruction appears on `Inst_Decode` 1 cycle after `Inst_Fetch`, and on `Inst_Execute` 2 cycles after. IMEM data arrives 1 cycle after its address.
- **Redirect at cycle t:**
  - t: `Inst_Decode`<=NOP at the edge.
  - t+1 (FLUSH): `control_hazards_sum`=1, `Inst_Fetch`=NOP, `imem_addr`=target.
  - t+2: `PC_Fetch`=target and `Inst_Fetch`=the target word.
  - Two wrong-path slots are squashed in total.
- **Hold at cycle t:** `imem_addr`=`PC_Fetch`, so the same word is re-presented at t+1. A bubble enters decode at t+1.
- **Reset mid-FLUSH:** return to RUN, drop `target_q`, apply all reset values. There is no pending redirect after release.
- **Simultaneous `counter_rst` and increment:** clear wins.

## Test plan

- **Reset:** hold `rst` 2 cycles.
  - During reset: `imem_addr`=0x4000_0000.
  - After release: `PC_Fetch`=0x4000_0000, `Inst_Decode`=`Inst_Execute`=0x13, `control_hazards_sum`=0, counters 0.
- **Straight-line fetch:** IMEM model returns `addi` words.
  - `imem_addr` steps 0x4000_0004, 0x4000_0008, ...
  - `Inst_Execute` equals `Inst_Fetch` from 2 cycles earlier.
  - `inst_count`=1 on the 3rd cycle after release; `cycle_count`=N after N cycles.
- **Hold 1 cycle at `PC_Fetch`=0x4000_0008:**
  - `imem_addr`=0x4000_0008 for 2 consecutive cycles.
  - `Inst_Decode`=NOP for 1 cycle.
  - The word at 0x4000_0008 reaches `Inst_Decode` one cycle later.
  - `inst_count` ends 1 lower than the no-stall run.
- **Redirect at t to 0x4000_0100:**
  - `control_hazards_sum`=1 only at t+1.
  - `Inst_Decode`=NOP at t+1 and t+2.
  - `PC_Fetch`=0x4000_0100 at t+2.
  - `PC_Decode`=0x4000_0100 at t+3.
- **Redirect with `Hold` at t, then `redirect_valid` again at t+1 (to 0x4000_0200):**
  - The first redirect is taken and the t+1 redirect is ignored.
  - `PC_Fetch`=0x4000_0100 at t+2.
- **Reset and counter clear:**
  - Assert `rst` during FLUSH: `control_hazards_sum`=0 and `PC_Fetch`=RESET_PC after release.
  - Pulse `counter_rst` mid-run: `cycle_count` reads 0, then 1 the next cycle.
